// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S receive/transmit types and default frame geometry
package i2s_pkg;
  typedef enum logic [1:0] {IDLE, HUNT, SHIFT, WAIT} state_t;
  localparam logic LEFT = 1'b0;
  localparam logic RIGHT = 1'b1;
  localparam int WIDTH_DEF = 24;
  localparam int SLOT_DEF = 32;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer with a registered rise on lane 0; q is retimed to align with rise
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise
);
  logic [W-1:0] s1, s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      q <= '0;
      rise <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      q <= s2;
      rise <= s2[0] & ~q[0];
    end
  end
endmodule

// File: rtl/i2s_line_in_rx.sv
// i2s_line_in_rx: deserializes codec I2S line-in into parallel left/right samples with a frame strobe
module i2s_line_in_rx
  import i2s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLOT = SLOT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2s_bclk,
  input  logic             i2s_lr,
  input  logic             i2s_sdata,
  output logic [WIDTH-1:0] left_out,
  output logic [WIDTH-1:0] right_out,
  output logic             new_frame,
  output logic             frame_err
);
  localparam int CW = $clog2(SLOT + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(SLOT);
  logic [2:0] sync_q;
  logic rise, lr, sdata, unused_bclk;
  state_t state, state_n;
  logic lr_prev, lr_prev_n, chan, chan_n, left_ok, left_ok_n, new_frame_n, frame_err_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n, left_hold, left_hold_n, left_out_n, right_out_n, word;
  sync_edge #(.W(3)) u_sync (
    .clk(clk),
    .reset(reset),
    .d({i2s_sdata, i2s_lr, i2s_bclk}),
    .q(sync_q),
    .rise(rise)
  );
  assign lr = sync_q[1];
  assign sdata = sync_q[2];
  assign unused_bclk = sync_q[0];
  assign word = {shreg[WIDTH-2:0], sdata};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lr_prev <= LEFT;
      chan <= LEFT;
      cnt <= '0;
      shreg <= '0;
      left_hold <= '0;
      left_ok <= 1'b0;
      left_out <= '0;
      right_out <= '0;
      new_frame <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      lr_prev <= lr_prev_n;
      chan <= chan_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      left_hold <= left_hold_n;
      left_ok <= left_ok_n;
      left_out <= left_out_n;
      right_out <= right_out_n;
      new_frame <= new_frame_n;
      frame_err <= frame_err_n;
    end
  end
  // An LR change always opens a new slot; the bit on that edge is the I2S one-bit delay
  always_comb begin
    state_n = state;
    lr_prev_n = lr_prev;
    chan_n = chan;
    cnt_n = cnt;
    shreg_n = shreg;
    left_hold_n = left_hold;
    left_ok_n = left_ok;
    left_out_n = left_out;
    right_out_n = right_out;
    new_frame_n = 1'b0;
    frame_err_n = frame_err;
    if (rise) begin
      lr_prev_n = lr;
      if (state == IDLE) state_n = HUNT;
      else if (lr != lr_prev) begin
        frame_err_n = frame_err | (state == SHIFT);
        chan_n = lr;
        cnt_n = '0;
        state_n = SHIFT;
      end else if (state == SHIFT) begin
        shreg_n = word;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = WAIT;
          if (chan == LEFT) begin
            left_hold_n = word;
            left_ok_n = 1'b1;
          end else if (left_ok) begin
            left_out_n = left_hold;
            right_out_n = word;
            new_frame_n = 1'b1;
            left_ok_n = 1'b0;
          end else frame_err_n = 1'b1;
        end
      end else if (state == WAIT) begin
        cnt_n = (cnt == CMAX) ? cnt : cnt + 1'b1;
        if (cnt_n == CMAX) begin
          frame_err_n = 1'b1;
          state_n = HUNT;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_line_in_rx.sv
// tb_i2s_line_in_rx: directed I2S frames with hand-computed expected samples and strobes
module tb_i2s_line_in_rx;
  logic clk = 1'b0, reset = 1'b1, i2s_bclk = 1'b0, i2s_lr = 1'b1, i2s_sdata = 1'b0;
  logic [23:0] left_out, right_out;
  logic new_frame, frame_err;
  int vectors = 0, miscompares = 0, hp = 16, cyc = 0;
  logic [23:0] p_l[$], p_r[$];
  int p_c[$];
  logic [23:0] rl, rr;
  logic rn, re;
  i2s_line_in_rx dut (
    .clk(clk),
    .reset(reset),
    .i2s_bclk(i2s_bclk),
    .i2s_lr(i2s_lr),
    .i2s_sdata(i2s_sdata),
    .left_out(left_out),
    .right_out(right_out),
    .new_frame(new_frame),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (new_frame) begin
      p_l.push_back(left_out);
      p_r.push_back(right_out);
      p_c.push_back(cyc);
    end
  end
  task automatic bit_edge(input logic l, input logic d);
    i2s_bclk = 1'b0;
    i2s_lr = l;
    i2s_sdata = d;
    repeat (hp) @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (hp) @(negedge clk);
  endtask
  task automatic send_slot(input logic l, input logic [23:0] w, input int n, input int rst_at);
    logic d;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        rl = left_out;
        rr = right_out;
        rn = new_frame;
        re = frame_err;
        reset = 1'b0;
      end
      d = 1'b0;
      if (i >= 1 && i <= 24) d = w[24-i];
      bit_edge(l, d);
    end
  endtask
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_slot(1'b0, l, 32, -1);
    send_slot(1'b1, r, 32, -1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    vectors += 4;
    if (left_out !== 24'h0) begin miscompares++; $display("FAIL reset left_out: got %h want 000000", left_out); end
    if (right_out !== 24'h0) begin miscompares++; $display("FAIL reset right_out: got %h want 000000", right_out); end
    if (new_frame !== 1'b0) begin miscompares++; $display("FAIL reset new_frame: got %b want 0", new_frame); end
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_clean_frame();
    int base;
    hp = 16;
    base = p_l.size();
    send_slot(1'b1, 24'h0, 4, -1);
    send_frame(24'hA5C3F0, 24'h0F1E2D);
    vectors += 4;
    if (p_l.size() - base !== 1) begin miscompares++; $display("FAIL clean pulses: got %0d want 1", p_l.size() - base); end
    if (left_out !== 24'hA5C3F0) begin miscompares++; $display("FAIL clean left_out: got %h want a5c3f0", left_out); end
    if (right_out !== 24'h0F1E2D) begin miscompares++; $display("FAIL clean right_out: got %h want 0f1e2d", right_out); end
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL clean frame_err: got %b want 0", frame_err); end
  endtask
  task automatic test_ramp();
    int base, n;
    hp = 4;
    base = p_l.size();
    for (int k = 1; k <= 100; k++) send_frame(24'(k), ~24'(k));
    n = p_l.size() - base;
    vectors++;
    if (n !== 100) begin miscompares++; $display("FAIL ramp pulses: got %0d want 100", n); end
    if (n > 100) n = 100;
    for (int i = 0; i < n; i++) begin
      vectors += 2;
      if (p_l[base+i] !== 24'(i + 1)) begin miscompares++; $display("FAIL ramp left[%0d]: got %h want %h", i, p_l[base+i], 24'(i + 1)); end
      if (p_r[base+i] !== ~24'(i + 1)) begin miscompares++; $display("FAIL ramp right[%0d]: got %h want %h", i, p_r[base+i], ~24'(i + 1)); end
      if (i > 0) begin
        vectors++;
        if (p_c[base+i] - p_c[base+i-1] !== 512) begin miscompares++; $display("FAIL ramp spacing[%0d]: got %0d want 512", i, p_c[base+i] - p_c[base+i-1]); end
      end
    end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL ramp frame_err: got %b want 0", frame_err); end
  endtask
  task automatic test_mid_slot_start();
    int base;
    hp = 8;
    do_reset();
    base = p_l.size();
    send_slot(1'b1, 24'hFFFFFF, 12, -1);
    send_frame(24'h123456, 24'h654321);
    vectors += 4;
    if (p_l.size() - base !== 1) begin miscompares++; $display("FAIL mid pulses: got %0d want 1", p_l.size() - base); end
    if (left_out !== 24'h123456) begin miscompares++; $display("FAIL mid left_out: got %h want 123456", left_out); end
    if (right_out !== 24'h654321) begin miscompares++; $display("FAIL mid right_out: got %h want 654321", right_out); end
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL mid frame_err: got %b want 0", frame_err); end
  endtask
  task automatic test_short_slot();
    int base;
    base = p_l.size();
    send_slot(1'b0, 24'hDEADBE, 11, -1);
    send_slot(1'b1, 24'h111111, 32, -1);
    vectors += 4;
    if (frame_err !== 1'b1) begin miscompares++; $display("FAIL short frame_err: got %b want 1", frame_err); end
    if (p_l.size() - base !== 0) begin miscompares++; $display("FAIL short pulses: got %0d want 0", p_l.size() - base); end
    if (left_out !== 24'h123456) begin miscompares++; $display("FAIL short held left: got %h want 123456", left_out); end
    if (right_out !== 24'h654321) begin miscompares++; $display("FAIL short held right: got %h want 654321", right_out); end
    send_frame(24'h2468AC, 24'h13579B);
    vectors += 4;
    if (p_l.size() - base !== 1) begin miscompares++; $display("FAIL short recover pulses: got %0d want 1", p_l.size() - base); end
    if (left_out !== 24'h2468AC) begin miscompares++; $display("FAIL short recover left: got %h want 2468ac", left_out); end
    if (right_out !== 24'h13579B) begin miscompares++; $display("FAIL short recover right: got %h want 13579b", right_out); end
    if (frame_err !== 1'b1) begin miscompares++; $display("FAIL short sticky err: got %b want 1", frame_err); end
  endtask
  task automatic test_timeout();
    int base;
    do_reset();
    base = p_l.size();
    send_slot(1'b1, 24'h0, 4, -1);
    send_slot(1'b0, 24'hC0FFEE, 65, -1);
    vectors += 2;
    if (frame_err !== 1'b1) begin miscompares++; $display("FAIL timeout frame_err: got %b want 1", frame_err); end
    if (p_l.size() - base !== 0) begin miscompares++; $display("FAIL timeout pulses: got %0d want 0", p_l.size() - base); end
    send_slot(1'b1, 24'hBADA55, 32, -1);
    send_frame(24'h00FF00, 24'hFF00FF);
    vectors++;
    if (p_l.size() - base !== 2) begin miscompares++; $display("FAIL timeout recover pulses: got %0d want 2", p_l.size() - base); end
    else begin
      vectors += 4;
      if (p_l[base] !== 24'hC0FFEE) begin miscompares++; $display("FAIL timeout left0: got %h want c0ffee", p_l[base]); end
      if (p_r[base] !== 24'hBADA55) begin miscompares++; $display("FAIL timeout right0: got %h want bada55", p_r[base]); end
      if (p_l[base+1] !== 24'h00FF00) begin miscompares++; $display("FAIL timeout left1: got %h want 00ff00", p_l[base+1]); end
      if (p_r[base+1] !== 24'hFF00FF) begin miscompares++; $display("FAIL timeout right1: got %h want ff00ff", p_r[base+1]); end
    end
  endtask
  task automatic test_reset_mid_word();
    int base;
    base = p_l.size();
    send_frame(24'hAAAAAA, 24'h555555);
    send_slot(1'b0, 24'h123ABC, 32, -1);
    send_slot(1'b1, 24'h456DEF, 32, 12);
    vectors += 4;
    if (rl !== 24'h0) begin miscompares++; $display("FAIL midreset left_out: got %h want 000000", rl); end
    if (rr !== 24'h0) begin miscompares++; $display("FAIL midreset right_out: got %h want 000000", rr); end
    if (rn !== 1'b0) begin miscompares++; $display("FAIL midreset new_frame: got %b want 0", rn); end
    if (re !== 1'b0) begin miscompares++; $display("FAIL midreset frame_err: got %b want 0", re); end
    send_frame(24'h0C0C0C, 24'h30F30F);
    vectors++;
    if (p_l.size() - base !== 2) begin miscompares++; $display("FAIL midreset pulses: got %0d want 2", p_l.size() - base); end
    else begin
      vectors += 3;
      if (p_l[base] !== 24'hAAAAAA) begin miscompares++; $display("FAIL midreset pre left: got %h want aaaaaa", p_l[base]); end
      if (p_l[base+1] !== 24'h0C0C0C) begin miscompares++; $display("FAIL midreset left: got %h want 0c0c0c", p_l[base+1]); end
      if (p_r[base+1] !== 24'h30F30F) begin miscompares++; $display("FAIL midreset right: got %h want 30f30f", p_r[base+1]); end
    end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL midreset final err: got %b want 0", frame_err); end
  endtask
  initial begin
    test_reset();
    test_clean_frame();
    test_ramp();
    test_mid_slot_start();
    test_short_slot();
    test_timeout();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
